// File: rtl/stage3_mdu_pkg.sv
// Shared definitions for the stage-3 M-extension execute unit:
// funct3 encodings, FSM state encoding and the default datapath width.
package stage3_mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_t;

endpackage

// File: rtl/stage3_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, WIDTH cycles.
// A start pulse loads the operands; a one-cycle done pulse follows the last iteration.
module stage3_div_core
    import stage3_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;

    // Dividend bits shift out of the quotient register into the partial remainder.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fit   = ~w_diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= CW'(WIDTH - 1);
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_dvs  <= i_divisor;
            end else if (r_busy) begin
                r_rem <= w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fit};
                if (r_cnt == '0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/stage3_muldiv_unit.sv
// Stage-3 RV32M execute unit: single-cycle registered multiply, iterative divide,
// divide special cases on a fast path, BUSY stall request to the hazard unit.
module stage3_muldiv_unit
    import stage3_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       MULDIV_SEL,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             DONE,
    output logic             BUSY
);

    localparam int unsigned  PW      = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_latch;
    logic [2:0]       r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_div_start;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    logic             w_a_sgn;
    logic             w_b_sgn;
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0] w_spec_res;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_div_res;

    // Divide-by-zero and signed overflow never go through the iterative divider.
    function automatic logic is_special(input logic [2:0] sel,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        return sel[2] & ((b == '0) | (~sel[0] & (a == SMIN) & (b == '1)));
    endfunction

    // Divider sees magnitudes for signed ops, taken straight from the live operands.
    always_comb begin
        w_abs_a = (~MULDIV_SEL[0] & DATA1[WIDTH-1]) ? -DATA1 : DATA1;
        w_abs_b = (~MULDIV_SEL[0] & DATA2[WIDTH-1]) ? -DATA2 : DATA2;
    end

    stage3_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk         (CLK),
        .rst_n       (RESET),
        .i_start     (w_div_start),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // Extending to 2*WIDTH gives the exact low 2*WIDTH product bits for every mix of signs.
    always_comb begin
        w_a_sgn   = (r_sel[1:0] != 2'b11);
        w_b_sgn   = ~r_sel[1];
        w_a_ext   = {{WIDTH{w_a_sgn & r_a[WIDTH-1]}}, r_a};
        w_b_ext   = {{WIDTH{w_b_sgn & r_b[WIDTH-1]}}, r_b};
        w_prod    = w_a_ext * w_b_ext;
        w_mul_res = (r_sel == MDU_MUL) ? w_prod[WIDTH-1:0] : w_prod[PW-1:WIDTH];
    end

    // Special-case and sign-corrected divider results; r_sel[1] selects remainder.
    always_comb begin
        if (r_b == '0) begin
            w_spec_res = r_sel[1] ? r_a : '1;
        end else begin
            w_spec_res = r_sel[1] ? '0 : SMIN;
        end
        w_quo_fix = (~r_sel[0] & (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_div_quo : w_div_quo;
        w_rem_fix = (~r_sel[0] & r_a[WIDTH-1]) ? -w_div_rem : w_div_rem;
        w_div_res = r_sel[1] ? w_rem_fix : w_quo_fix;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_latch      = 1'b0;
        w_div_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_latch = 1'b1;
                    if (!MULDIV_SEL[2] || is_special(MULDIV_SEL, DATA1, DATA2)) begin
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_state_nxt = ST_DIV;
                        w_div_start = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_result_nxt = r_sel[2] ? w_spec_res : w_mul_res;
                w_done_nxt   = 1'b1;
                w_state_nxt  = ST_DONE;
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_result_nxt = w_div_res;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_result <= w_result_nxt;
            r_done   <= w_done_nxt;
            if (w_latch) begin
                r_sel <= MULDIV_SEL;
                r_a   <= DATA1;
                r_b   <= DATA2;
            end
        end
    end

    assign RESULT = r_result;
    assign DONE   = r_done;
    // Low in the DONE cycle so the stage-3/4 register captures RESULT.
    assign BUSY   = RESET & ((r_state == ST_MUL) | (r_state == ST_DIV) |
                             ((r_state == ST_IDLE) & START));

endmodule

// File: tb/tb_stage3_muldiv_unit.sv
// Bench for stage3_muldiv_unit: directed and random ops, scoreboard of expected
// results and DONE cycles, reference model in plain integer arithmetic.
module tb_stage3_muldiv_unit;
    import stage3_mdu_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [2:0]  MULDIV_SEL;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [31:0] RESULT;
    logic        DONE;
    logic        BUSY;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] last_exp;
    bit          have_last;

    stage3_muldiv_unit #(.WIDTH(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .MULDIV_SEL (MULDIV_SEL),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .RESULT     (RESULT),
        .DONE       (DONE),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] sel,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        int          ia, ib;
        sa = $signed(a);
        sb = $signed(b);
        ia = a;
        ib = b;
        case (sel)
            MDU_MUL:    return a * b;
            MDU_MULH:   begin p = sa * sb;                   return p[63:32]; end
            MDU_MULHSU: begin p = sa * longint'({32'b0, a} & 64'h0) + sa * longint'({32'b0, b}); return p[63:32]; end
            MDU_MULHU:  begin p = {32'b0, a} * {32'b0, b};  return p[63:32]; end
            MDU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel[2] || b == 0) return 2;
        if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (DONE) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual RESULT=%h, no operation outstanding (cycle %0d)", RESULT, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("result", RESULT, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one op in the current cycle and keep the instruction stalled in
    // stage 3 until its DONE cycle; forwarded operands wander after acceptance.
    task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [31:0] e;
        @(negedge CLK);
        if (have_last) chk("result_hold", RESULT, last_exp);
        e   = ref_result(sel, a, b);
        lat = ref_lat(sel, a, b);
        START      = 1'b1;
        MULDIV_SEL = sel;
        DATA1      = a;
        DATA2      = b;
        sb_q.push_back('{res: e, cyc: cyc + lat});
        #1 chk("busy_start", 32'(BUSY), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLK);
            DATA1      = $urandom;
            DATA2      = $urandom;
            MULDIV_SEL = 3'($urandom);
            #1 chk((k == lat) ? "busy_done_cycle" : "busy_wait", 32'(BUSY), (k < lat) ? 32'd1 : 32'd0);
        end
        last_exp  = e;
        have_last = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            START = 1'b0;
            DATA1 = $urandom;
            DATA2 = $urandom;
            #1 chk("busy_idle", 32'(BUSY), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rs;
        checks    = 0;
        errors    = 0;
        have_last = 1'b0;
        last_exp  = '0;

        // Reset with START asserted: outputs and BUSY must stay low.
        RESET      = 1'b0;
        START      = 1'b1;
        MULDIV_SEL = MDU_DIV;
        DATA1      = 32'h1234_5678;
        DATA2      = 32'h0000_0003;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_result", RESULT, 32'h0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        START = 1'b0;
        RESET = 1'b1;
        idle(2);

        // Directed cases, issued back-to-back.
        issue(MDU_MUL,    32'hFFFF_FFFE, 32'h0000_0003);
        issue(MDU_MULH,   32'h8000_0000, 32'h8000_0000);
        issue(MDU_MULHU,  32'h8000_0000, 32'h8000_0000);
        issue(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002);
        issue(MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002);
        issue(MDU_DIVU,   32'h0000_1234, 32'h0000_0000);
        issue(MDU_REM,    32'h0000_1234, 32'h0000_0000);
        issue(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        issue(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF);
        issue(MDU_DIVU,   32'd100,       32'd7);
        issue(MDU_MUL,    32'd5,         32'd6);

        // Reset in cycle 10 of a divide aborts it with no DONE.
        @(negedge CLK);
        chk("result_hold", RESULT, last_exp);
        START      = 1'b1;
        MULDIV_SEL = MDU_DIV;
        DATA1      = 32'hFFFF_FFF9;
        DATA2      = 32'h0000_0002;
        for (int k = 1; k < 10; k++) begin
            @(negedge CLK);
            #1 chk("busy_pre_abort", 32'(BUSY), 32'd1);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("abort_result", RESULT, 32'h0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RESET     = 1'b1;
        START     = 1'b0;
        last_exp  = 32'h0;
        have_last = 1'b1;
        idle(1);
        issue(MDU_DIVU, 32'd9, 32'd3);

        // Random ops, biased towards the divide corner cases.
        for (int n = 0; n < 60; n++) begin
            rs = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: begin ra = 32'($urandom_range(0, 50)); rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7)); end
                4: ra = {1'b1, 31'($urandom)};
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) idle(32'($urandom_range(1, 3)));
            issue(rs, ra, rb);
        end

        idle(5);
        chk("outstanding_ops", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
